// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode constants, data width and driver FSM state
//               encoding for the 8-bit registered ALU and its command driver.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   // Datapath width of the ALU operands and result
   localparam int DATA_W = 8;

   // ALU select codes that the driver needs to recognise by name
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_MUL = 4'b0010;
   localparam logic [3:0] ALU_DIV = 4'b0011;

   // Command driver FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } drv_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_driver
// Description : Valid/ready command front end for the registered ALU. Loads
//               operands, waits out the ALU latency, captures the result and
//               returns it as a tagged response. Divide-by-zero commands are
//               answered immediately with an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_driver
   import alu_pkg::*;
#(
   parameter int ALU_LATENCY = 1,
   parameter int CNT_W       = 16
) (
   input  logic              clock,
   input  logic              reset,
   // command channel
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [3:0]        cmd_op,
   // ALU side
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_carry,
   // response channel
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_carry,
   output logic [3:0]        rsp_op,
   output logic              rsp_err,
   output logic [CNT_W-1:0]  txn_count
);

   // A zero-latency ALU still needs a one-bit counter to exist
   localparam int               LAT_W    = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LATENCY);

   drv_state_t        r_state;
   drv_state_t        w_next_state;
   logic [LAT_W-1:0]  r_lat_cnt;

   logic              w_accept;
   logic              w_div_zero;
   logic              w_capture;
   logic              w_complete;

   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [3:0]        r_alu_sel;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_carry;
   logic [3:0]        r_rsp_op;
   logic              r_rsp_err;
   logic [CNT_W-1:0]  r_txn_count;

   // Next-state decode and the per-edge strobes that steer the datapath
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_div_zero   = 1'b0;
      w_capture    = 1'b0;
      w_complete   = 1'b0;
      case (r_state)
         IDLE: begin
            if (cmd_valid) begin
               w_accept = 1'b1;
               if ((cmd_op == ALU_DIV) && (cmd_b == '0)) begin
                  w_div_zero   = 1'b1;
                  w_next_state = RESP;
               end else begin
                  w_next_state = WAIT;
               end
            end
         end
         WAIT: begin
            if (r_lat_cnt == '0) begin
               w_capture    = 1'b1;
               w_next_state = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               w_complete   = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // State register and ALU latency down-counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_lat_cnt <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept && !w_div_zero) begin
            r_lat_cnt <= LAT_LOAD;
         end else if ((r_state == WAIT) && (r_lat_cnt != '0)) begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
         end
      end
   end

   // Operand hold registers, response capture and completed-transaction count
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_sel   <= '0;
         r_rsp_data  <= '0;
         r_rsp_carry <= 1'b0;
         r_rsp_op    <= '0;
         r_rsp_err   <= 1'b0;
         r_txn_count <= '0;
      end else begin
         if (w_accept) begin
            r_rsp_op <= cmd_op;
            if (w_div_zero) begin
               // ALU inputs are left alone so the ALU never sees the bad divide
               r_rsp_err   <= 1'b1;
               r_rsp_data  <= '0;
               r_rsp_carry <= 1'b0;
            end else begin
               r_alu_a   <= cmd_a;
               r_alu_b   <= cmd_b;
               r_alu_sel <= cmd_op;
            end
         end
         if (w_capture) begin
            r_rsp_data  <= alu_out;
            r_rsp_carry <= alu_carry;
            r_rsp_err   <= 1'b0;
         end
         if (w_complete) begin
            r_txn_count <= r_txn_count + 1'b1;
         end
      end
   end

   // Ready is forced low for as long as reset is held, not just at the edge
   assign cmd_ready = (r_state == IDLE) && !reset;
   assign rsp_valid = (r_state == RESP);

   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_sel   = r_alu_sel;
   assign rsp_data  = r_rsp_data;
   assign rsp_carry = r_rsp_carry;
   assign rsp_op    = r_rsp_op;
   assign rsp_err   = r_rsp_err;
   assign txn_count = r_txn_count;

endmodule : alu_cmd_driver
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_driver
// Description : Directed self-checking bench. Instance 0 uses the default
//               parameters; instance 1 uses ALU_LATENCY=3, CNT_W=4 for the
//               reset-during-WAIT and counter wrap scenarios. Each instance
//               is paired with a one-stage registered ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_driver;
   import alu_pkg::*;

   localparam int L0 = 1;
   localparam int L1 = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // instance 0 (ALU_LATENCY=1, CNT_W=16)
   logic        cmd_valid0 = 1'b0, rsp_ready0 = 1'b0;
   logic [7:0]  cmd_a0 = '0, cmd_b0 = '0;
   logic [3:0]  cmd_op0 = '0;
   logic        cmd_ready0, rsp_valid0, rsp_carry0, rsp_err0, alu_carry0;
   logic [7:0]  alu_a0, alu_b0, alu_out0, rsp_data0;
   logic [3:0]  alu_sel0, rsp_op0;
   logic [15:0] txn_count0;

   // instance 1 (ALU_LATENCY=3, CNT_W=4)
   logic        cmd_valid1 = 1'b0, rsp_ready1 = 1'b0;
   logic [7:0]  cmd_a1 = '0, cmd_b1 = '0;
   logic [3:0]  cmd_op1 = '0;
   logic        cmd_ready1, rsp_valid1, rsp_carry1, rsp_err1, alu_carry1;
   logic [7:0]  alu_a1, alu_b1, alu_out1, rsp_data1;
   logic [3:0]  alu_sel1, rsp_op1;
   logic [3:0]  txn_count1;

   alu_cmd_driver #(.ALU_LATENCY(L0), .CNT_W(16)) u_dut0 (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
      .cmd_a(cmd_a0), .cmd_b(cmd_b0), .cmd_op(cmd_op0),
      .alu_a(alu_a0), .alu_b(alu_b0), .alu_sel(alu_sel0),
      .alu_out(alu_out0), .alu_carry(alu_carry0),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
      .rsp_data(rsp_data0), .rsp_carry(rsp_carry0), .rsp_op(rsp_op0),
      .rsp_err(rsp_err0), .txn_count(txn_count0)
   );

   alu_cmd_driver #(.ALU_LATENCY(L1), .CNT_W(4)) u_dut1 (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
      .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_op(cmd_op1),
      .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1),
      .alu_out(alu_out1), .alu_carry(alu_carry1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .rsp_data(rsp_data1), .rsp_carry(rsp_carry1), .rsp_op(rsp_op1),
      .rsp_err(rsp_err1), .txn_count(txn_count1)
   );

   // Registered ALU stand-in: {carry, result}
   function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] sel);
      case (sel)
         ALU_ADD: return {1'b0, a} + {1'b0, b};
         ALU_SUB: return {1'b0, a} - {1'b0, b};
         ALU_MUL: return {1'b0, 8'(a * b)};
         ALU_DIV: return (b == 8'd0) ? 9'h000 : {1'b0, 8'(a / b)};
         default: return {1'b0, a ^ b};
      endcase
   endfunction

   always @(posedge clock) begin
      {alu_carry0, alu_out0} <= alu_model(alu_a0, alu_b0, alu_sel0);
      {alu_carry1, alu_out1} <= alu_model(alu_a1, alu_b1, alu_sel1);
   end

   // Back-to-back command table with hand-computed results
   logic [7:0] bb_a  [4] = '{8'd200, 8'd50, 8'd4, 8'd30};
   logic [7:0] bb_b  [4] = '{8'd100, 8'd30, 8'd5, 8'd5};
   logic [3:0] bb_op [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011};
   logic [7:0] bb_d  [4] = '{8'd44, 8'd20, 8'd20, 8'd6};
   logic       bb_c  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present one command on instance 0 and wait (bounded) for rsp_valid
   task automatic issue0(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         output int lat);
      cmd_a0 = a; cmd_b0 = b; cmd_op0 = op; cmd_valid0 = 1'b1;
      tick();
      cmd_valid0 = 1'b0;
      lat = 0;
      while (!rsp_valid0 && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic issue1(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         output int lat);
      cmd_a1 = a; cmd_b1 = b; cmd_op1 = op; cmd_valid1 = 1'b1;
      tick();
      cmd_valid1 = 1'b0;
      lat = 0;
      while (!rsp_valid1 && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   // Bounded safety net in case the sequence below ever stalls
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, idx, nrsp, rdy_cnt, cyc, seen;
      logic acc, hs;

      // ---------------- reset state ----------------
      repeat (2) tick();
      chk("rst_cmd_ready0", cmd_ready0, 0);
      chk("rst_cmd_ready1", cmd_ready1, 0);
      chk("rst_rsp_valid0", rsp_valid0, 0);
      chk("rst_rsp_data0", rsp_data0, 0);
      chk("rst_rsp_err0", rsp_err0, 0);
      chk("rst_alu_a0", alu_a0, 0);
      chk("rst_alu_sel0", alu_sel0, 0);
      chk("rst_txn_count0", txn_count0, 0);
      reset = 1'b0;
      #1;
      chk("post_rst_cmd_ready0", cmd_ready0, 1);
      chk("post_rst_cmd_ready1", cmd_ready1, 1);

      // ---------------- ADD 10+5 ----------------
      issue0(8'd10, 8'd5, ALU_ADD, lat);
      chk("add_latency", lat, L0 + 1);
      chk("add_data", rsp_data0, 15);
      chk("add_carry", rsp_carry0, 0);
      chk("add_err", rsp_err0, 0);
      chk("add_op", rsp_op0, 4'b0000);
      chk("add_alu_a", alu_a0, 10);
      chk("add_alu_b", alu_b0, 5);
      rsp_ready0 = 1'b1;
      tick();
      rsp_ready0 = 1'b0;
      chk("add_hs_valid", rsp_valid0, 0);
      chk("add_hs_ready", cmd_ready0, 1);
      chk("add_txn_count", txn_count0, 1);

      // ---------------- back-to-back with cmd_valid held ----------------
      idx = 0; nrsp = 0; rdy_cnt = 0; cyc = 0;
      cmd_a0 = bb_a[0]; cmd_b0 = bb_b[0]; cmd_op0 = bb_op[0];
      cmd_valid0 = 1'b1;
      rsp_ready0 = 1'b1;
      while (nrsp < 4 && cyc < 80) begin
         acc = cmd_ready0 && cmd_valid0;
         hs  = rsp_valid0 && rsp_ready0;
         if (cmd_ready0) rdy_cnt++;
         if (hs) begin
            chk("b2b_data", rsp_data0, bb_d[nrsp]);
            chk("b2b_carry", rsp_carry0, bb_c[nrsp]);
            chk("b2b_err", rsp_err0, 0);
            chk("b2b_op", rsp_op0, bb_op[nrsp]);
            chk("b2b_ready_once", rdy_cnt, 1);
            nrsp++;
            rdy_cnt = 0;
         end
         tick();
         cyc++;
         if (acc) begin
            idx++;
            if (idx < 4) begin
               cmd_a0 = bb_a[idx]; cmd_b0 = bb_b[idx]; cmd_op0 = bb_op[idx];
            end else begin
               cmd_valid0 = 1'b0;
            end
         end
      end
      cmd_valid0 = 1'b0;
      rsp_ready0 = 1'b0;
      chk("b2b_responses", nrsp, 4);
      chk("b2b_txn_count", txn_count0, 5);

      // ---------------- DIV 20/0 ----------------
      issue0(8'd20, 8'd0, ALU_DIV, lat);
      chk("dz_latency", lat, 0);
      chk("dz_err", rsp_err0, 1);
      chk("dz_data", rsp_data0, 0);
      chk("dz_carry", rsp_carry0, 0);
      chk("dz_op", rsp_op0, 4'b0011);
      chk("dz_alu_a_kept", alu_a0, 30);
      chk("dz_alu_b_kept", alu_b0, 5);
      chk("dz_alu_sel_kept", alu_sel0, 4'b0011);
      rsp_ready0 = 1'b1;
      tick();
      rsp_ready0 = 1'b0;
      chk("dz_txn_count", txn_count0, 6);

      // ---------------- backpressure on SUB 15-5 ----------------
      issue0(8'd15, 8'd5, ALU_SUB, lat);
      chk("bp_latency", lat, L0 + 1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", rsp_valid0, 1);
         chk("bp_data", rsp_data0, 10);
         chk("bp_op", rsp_op0, 4'b0001);
         chk("bp_err", rsp_err0, 0);
         chk("bp_cmd_ready", cmd_ready0, 0);
         chk("bp_txn_count", txn_count0, 6);
         tick();
      end
      rsp_ready0 = 1'b1;
      tick();
      rsp_ready0 = 1'b0;
      chk("bp_release_valid", rsp_valid0, 0);
      chk("bp_release_count", txn_count0, 7);

      // ---------------- reset pulse mid-WAIT (latency 3) ----------------
      cmd_a1 = 8'd1; cmd_b1 = 8'd2; cmd_op1 = ALU_ADD; cmd_valid1 = 1'b1;
      tick();
      cmd_valid1 = 1'b0;
      tick();
      chk("mw_alu_a_loaded", alu_a1, 1);
      chk("mw_in_wait", cmd_ready1, 0);
      #2 reset = 1'b1;
      #1;
      chk("mw_rst_cmd_ready", cmd_ready1, 0);
      chk("mw_rst_valid", rsp_valid1, 0);
      chk("mw_rst_alu_a", alu_a1, 0);
      chk("mw_rst_alu_b", alu_b1, 0);
      chk("mw_rst_alu_sel", alu_sel1, 0);
      chk("mw_rst_rsp_op", rsp_op1, 0);
      chk("mw_rst_txn_count0", txn_count0, 0);
      tick();
      reset = 1'b0;
      #1;
      chk("mw_post_rst_ready", cmd_ready1, 1);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (rsp_valid1) seen++;
         tick();
      end
      chk("mw_no_response", seen, 0);
      issue1(8'd7, 8'd8, ALU_ADD, lat);
      chk("mw_next_latency", lat, L1 + 1);
      chk("mw_next_data", rsp_data1, 15);
      rsp_ready1 = 1'b1;
      tick();
      rsp_ready1 = 1'b0;
      chk("mw_next_txn_count", txn_count1, 1);

      // ---------------- txn_count wrap with CNT_W=4 ----------------
      for (int i = 2; i <= 17; i++) begin
         issue1(8'(i), 8'd1, ALU_ADD, lat);
         if (i == 17) chk("wrap_data", rsp_data1, 18);
         rsp_ready1 = 1'b1;
         tick();
         rsp_ready1 = 1'b0;
         if (i == 15) chk("wrap_count_15", txn_count1, 15);
         if (i == 16) chk("wrap_count_0", txn_count1, 0);
         if (i == 17) chk("wrap_count_1", txn_count1, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_alu_cmd_driver
`default_nettype wire
